button_event_decoder: RTL and testbench

- Input-side counterpart to the board LED/counter logic. Takes the raw active-low push-button pins (but1, but2, ...) and turns them into clean, single-cycle, clock-domain events for user-control logic.
- Per button: 2-FF synchroniser, debounce, stable level, and press / release / long-press / auto-repeat pulses.
- Sits directly behind the top-level button pins, in the 10 MHz clk domain from the clock wizard.

---
 rtl/btn_pkg.sv | 21 ++
 rtl/btn_channel.sv | 156 +++++++++++++++
 rtl/button_event_decoder.sv | 37 +++
 tb/tb_button_event_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and timing constants for the push-button event decoder.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        LONG_HELD,
        DEB_RELEASE
    } btn_state_t;

    localparam int CLK_HZ    = 10_000_000;
    localparam int DEB_10MS  = CLK_HZ / 100;
    localparam int LONG_1S   = CLK_HZ;
    localparam int REP_250MS = CLK_HZ / 4;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, debounce FSM and hold/repeat counters.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEB_10MS,
    parameter int LONG_CYC     = LONG_1S,
    parameter int REPEAT_CYC   = REP_250MS
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic rep_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYC);
    localparam int HW = cnt_width(LONG_CYC);
    localparam int RW = cnt_width(REPEAT_CYC);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    // long fires on the (LONG_CYC-1)th counted hold cycle after the press edge
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 2);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

    btn_state_t    state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          long_flag_q, long_flag_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic          pressed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            dcnt_q      <= '0;
            hcnt_q      <= '0;
            rcnt_q      <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            rep_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dcnt_q      <= dcnt_d;
            hcnt_q      <= hcnt_d;
            rcnt_q      <= rcnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            rep_q       <= rep_d;
        end
    end

    always_comb begin
        sync1_d     = btn_n_i;
        sync2_d     = sync1_q;
        pressed     = ~sync2_q;
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hcnt_d      = hcnt_q;
        rcnt_d      = rcnt_q;
        long_flag_d = long_flag_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        rep_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = DEB_PRESS;
                    dcnt_d  = '0;
                end
            end
            DEB_PRESS: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d     = HELD;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    hcnt_d      = '0;
                    long_flag_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!pressed) begin
                    state_d = DEB_RELEASE;
                    dcnt_d  = '0;
                end else if (hcnt_q == LONG_LAST) begin
                    state_d     = LONG_HELD;
                    long_d      = 1'b1;
                    long_flag_d = 1'b1;
                    hcnt_d      = '0;
                    rcnt_d      = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            LONG_HELD: begin
                if (!pressed) begin
                    state_d = DEB_RELEASE;
                    dcnt_d  = '0;
                end else if (REPEAT_CYC != 0) begin
                    if (rcnt_q == REP_LAST) begin
                        rep_d  = 1'b1;
                        rcnt_d = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end
            DEB_RELEASE: begin
                // hcnt/rcnt stay frozen so a release bounce resumes the hold
                if (pressed) begin
                    state_d = long_flag_q ? LONG_HELD : HELD;
                end else if (dcnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign rep_o     = rep_q;

endmodule

// File: rtl/button_event_decoder.sv
// Debounced press/release/long/repeat events for NUM_BTN active-low buttons.
module button_event_decoder
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 2,
    parameter int DEBOUNCE_CYC = DEB_10MS,
    parameter int LONG_CYC     = LONG_1S,
    parameter int REPEAT_CYC   = REP_250MS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n_i,
    output logic [NUM_BTN-1:0] level_o,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] long_o,
    output logic [NUM_BTN-1:0] rep_o
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .btn_n_i   (btn_n_i[i]),
            .level_o   (level_o[i]),
            .press_o   (press_o[i]),
            .release_o (release_o[i]),
            .long_o    (long_o[i]),
            .rep_o     (rep_o[i])
        );
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: run-length reference model plus directed scenarios.
module tb_button_event_decoder;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_n_i = '1;
    logic [NB-1:0] level_o, press_o, release_o, long_o, rep_o;
    logic [0:0]    nr_btn_n = 1'b1;
    logic [0:0]    nr_level, nr_press, nr_release, nr_long, nr_rep;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .NUM_BTN(NB), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .REPEAT_CYC(REP)
    ) dut (
        .clk(clk), .rst(rst), .btn_n_i(btn_n_i), .level_o(level_o), .press_o(press_o),
        .release_o(release_o), .long_o(long_o), .rep_o(rep_o)
    );

    button_event_decoder #(
        .NUM_BTN(1), .DEBOUNCE_CYC(DEB), .LONG_CYC(LNG), .REPEAT_CYC(0)
    ) dut_norep (
        .clk(clk), .rst(rst), .btn_n_i(nr_btn_n), .level_o(nr_level), .press_o(nr_press),
        .release_o(nr_release), .long_o(nr_long), .rep_o(nr_rep)
    );

    logic [5*NB-1:0] obs, expv;
    logic [4:0]      nr_obs;
    assign obs    = {level_o, press_o, release_o, long_o, rep_o};
    assign nr_obs = {nr_level, nr_press, nr_release, nr_long, nr_rep};

    // Reference model: a change is accepted after DEB+1 consecutive disagreeing
    // samples of the synchronised pin; hold time counts only agreeing samples
    // that follow another agreeing sample.
    bit            m_sp1 [NB];
    bit            m_sp2 [NB];
    bit            m_level [NB];
    bit            m_ld [NB];
    int            m_run [NB];
    int            m_hc [NB];
    int            m_rc [NB];
    bit            m_s;
    logic [NB-1:0] e_level, e_press, e_release, e_long, e_rep;

    initial begin
        forever begin
            @(posedge clk);
            e_press = '0; e_release = '0; e_long = '0; e_rep = '0;
            for (int i = 0; i < NB; i++) begin
                if (rst) begin
                    m_sp1[i] = 1'b1; m_sp2[i] = 1'b1; m_level[i] = 1'b0; m_ld[i] = 1'b0;
                    m_run[i] = 0; m_hc[i] = 0; m_rc[i] = 0;
                end else begin
                    m_s = !m_sp2[i];
                    m_sp2[i] = m_sp1[i];
                    m_sp1[i] = btn_n_i[i];
                    if (m_s != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB + 1) begin
                            m_level[i] = m_s;
                            m_run[i] = 0;
                            if (m_s) begin
                                e_press[i] = 1'b1; m_hc[i] = 0; m_ld[i] = 1'b0;
                            end else begin
                                e_release[i] = 1'b1;
                            end
                        end
                    end else begin
                        if (m_run[i] == 0 && m_level[i]) begin
                            if (!m_ld[i]) begin
                                m_hc[i]++;
                                if (m_hc[i] == LNG - 1) begin
                                    e_long[i] = 1'b1; m_ld[i] = 1'b1; m_rc[i] = 0;
                                end
                            end else begin
                                m_rc[i]++;
                                if (m_rc[i] == REP) begin
                                    e_rep[i] = 1'b1; m_rc[i] = 0;
                                end
                            end
                        end
                        m_run[i] = 0;
                    end
                end
                e_level[i] = m_level[i];
            end
            expv = {e_level, e_press, e_release, e_long, e_rep};
        end
    end

    task automatic idle(input int n);
        btn_n_i  = '1;
        nr_btn_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_n_i = '1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== '0 || nr_obs !== '0)
                $display("FAIL reset_outputs obs=%b nr=%b required all zero", obs, nr_obs);
            if (obs !== '0 || nr_obs !== '0) miscompares++;
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_clean_press();
        int press_at = -1, long_at = -1, rel_at = -1, rep_first = -1, rep_cnt = 0, lvl_bad = 0;
        for (int n = 1; n <= 70; n++) begin
            btn_n_i[0] = (n >= 51);
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL clean_model n=%0d got=%b want=%b", n, obs, expv);
            end
            if (press_o[0] && press_at < 0) press_at = n;
            if (long_o[0] && long_at < 0) long_at = n;
            if (release_o[0] && rel_at < 0) rel_at = n;
            if (rep_o[0]) begin
                rep_cnt++;
                if (rep_first < 0) rep_first = n;
            end
            if (n >= 7 && n <= 56 && level_o[0] !== 1'b1) lvl_bad++;
        end
        vectors++;
        if (press_at !== 7) begin miscompares++; $display("FAIL clean_press_at got=%0d want=7", press_at); end
        vectors++;
        if (long_at !== 26) begin miscompares++; $display("FAIL clean_long_at got=%0d want=26", long_at); end
        vectors++;
        if (rep_cnt !== 5 || rep_first !== 31) begin
            miscompares++;
            $display("FAIL clean_rep count=%0d first=%0d want 5 and 31", rep_cnt, rep_first);
        end
        vectors++;
        if (rel_at !== 57) begin miscompares++; $display("FAIL clean_release_at got=%0d want=57", rel_at); end
        vectors++;
        if (lvl_bad !== 0 || level_o[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL clean_level bad_cycles=%0d final=%b want 0 and 0", lvl_bad, level_o[0]);
        end
        idle(5);
    endtask

    task automatic test_bounce();
        int evt = 0;
        for (int n = 1; n <= 35; n++) begin
            btn_n_i[1] = (n <= 25) ? (((n - 1) % 5) >= 3) : 1'b1;
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL bounce_model n=%0d got=%b want=%b", n, obs, expv);
            end
            if ((press_o | release_o | long_o | rep_o | level_o) !== '0) evt++;
        end
        vectors++;
        if (evt !== 0) begin miscompares++; $display("FAIL bounce_events got=%0d want=0", evt); end
    endtask

    task automatic test_release_bounce();
        int long_at = -1, rel_at = -1, rel_cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            btn_n_i[0] = (n == 10 || n == 11 || n >= 45);
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL relbounce_model n=%0d got=%b want=%b", n, obs, expv);
            end
            if (long_o[0] && long_at < 0) long_at = n;
            if (release_o[0]) begin
                rel_cnt++;
                rel_at = n;
            end
        end
        vectors++;
        if (long_at !== 29) begin miscompares++; $display("FAIL relbounce_long_at got=%0d want=29", long_at); end
        vectors++;
        if (rel_cnt !== 1 || rel_at !== 51) begin
            miscompares++;
            $display("FAIL relbounce_release count=%0d at=%0d want 1 at 51", rel_cnt, rel_at);
        end
        idle(5);
    endtask

    task automatic test_simultaneous();
        for (int n = 1; n <= 52; n++) begin
            btn_n_i = (n >= 41) ? 2'b11 : 2'b00;
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL simul_model n=%0d got=%b want=%b", n, obs, expv);
            end
            if (n == 7) begin
                vectors++;
                if (press_o !== 2'b11) begin miscompares++; $display("FAIL simul_press got=%b want=11", press_o); end
            end
            if (n == 26) begin
                vectors++;
                if (long_o !== 2'b11) begin miscompares++; $display("FAIL simul_long got=%b want=11", long_o); end
            end
            if (n == 47) begin
                vectors++;
                if (release_o !== 2'b11) begin miscompares++; $display("FAIL simul_release got=%b want=11", release_o); end
            end
        end
        idle(5);
    endtask

    task automatic test_reset_mid_hold();
        int press_at = -1, rel_cnt = 0;
        for (int n = 1; n <= 30; n++) begin
            btn_n_i[0] = 1'b0;
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL midrst_model n=%0d got=%b want=%b", n, obs, expv);
            end
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        vectors++;
        if (obs !== '0) begin miscompares++; $display("FAIL midrst_clear got=%b want=0", obs); end
        rst = 1'b0;
        for (int m = 1; m <= 12; m++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL midrst_model m=%0d got=%b want=%b", m, obs, expv);
            end
            if (press_o[0] && press_at < 0) press_at = m;
            if (release_o[0]) rel_cnt++;
        end
        vectors++;
        if (press_at !== 7) begin miscompares++; $display("FAIL midrst_repress got=%0d want=7", press_at); end
        vectors++;
        if (rel_cnt !== 0) begin miscompares++; $display("FAIL midrst_release got=%0d want=0", rel_cnt); end
        idle(12);
    endtask

    task automatic test_no_repeat();
        int press_cnt = 0, long_cnt = 0, long_at = -1, rep_cnt = 0, rel_at = -1;
        for (int n = 1; n <= 112; n++) begin
            nr_btn_n = (n >= 101);
            @(posedge clk); @(negedge clk);
            if (nr_press[0]) press_cnt++;
            if (nr_long[0]) begin
                long_cnt++;
                long_at = n;
            end
            if (nr_rep[0]) rep_cnt++;
            if (nr_release[0]) rel_at = n;
        end
        vectors++;
        if (press_cnt !== 1) begin miscompares++; $display("FAIL norep_press got=%0d want=1", press_cnt); end
        vectors++;
        if (long_cnt !== 1 || long_at !== 26) begin
            miscompares++;
            $display("FAIL norep_long count=%0d at=%0d want 1 at 26", long_cnt, long_at);
        end
        vectors++;
        if (rep_cnt !== 0) begin miscompares++; $display("FAIL norep_rep got=%0d want=0", rep_cnt); end
        vectors++;
        if (rel_at !== 107) begin miscompares++; $display("FAIL norep_release got=%0d want=107", rel_at); end
        idle(5);
    endtask

    task automatic test_random();
        int rem [NB];
        for (int i = 0; i < NB; i++) rem[i] = 1;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < NB; i++) begin
                rem[i]--;
                if (rem[i] <= 0) begin
                    btn_n_i[i] = ~btn_n_i[i];
                    case ($urandom_range(0, 3))
                        0:       rem[i] = $urandom_range(1, 3);
                        1:       rem[i] = $urandom_range(3, 7);
                        2:       rem[i] = $urandom_range(8, 40);
                        default: rem[i] = $urandom_range(30, 90);
                    endcase
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            @(posedge clk); @(negedge clk);
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL random_model n=%0d rst=%b pins=%b got=%b want=%b", n, rst, btn_n_i, obs, expv);
            end
        end
        rst = 1'b0;
        idle(5);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_reset_mid_hold();
        test_no_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
